shift_amt_unit: RTL and testbench

SHIFT_AMT_UNIT -- requirements
Module: shift_amt_unit

---
 rtl/shift_amt_unit.sv | 134 +++++++++++++
 tb/tb_shift_amt_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shift_amt_unit.sv
// shift_amt_unit: multi-cycle barrel-free shifter that moves the operand one
// bit per clock under a small IDLE/SHIFT/DONE controller.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   reset    - synchronous active-high reset, wins over start
//   start    - request a shift; only sampled in IDLE or DONE
//   amt_sel  - amount source: 00 shamt, 01 mdr_amt, 10 b_amt, 11 DATA_W/2
//   op       - 00 SLL, 01 SRL, 10 SRA, 11 ROR (SRL when rotate is disabled)
//   shamt    - instruction shift field
//   mdr_amt  - memory-data-register low bits
//   b_amt    - register B low bits
//   data_in  - operand latched on an accepted start
//   data_out - working/result register, holds the result after DONE
//   busy     - high while in SHIFT
//   done     - high for one cycle when the result is final
//
// Configuration macro: SHIFT_ROTATE_EN enables op=11 as rotate-right; when
// undefined op=11 behaves as SRL and no rotate path is built.
module shift_amt_unit #(
  parameter int unsigned AMT_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        amt_sel,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [AMT_W-1:0]  mdr_amt,
  input  logic [AMT_W-1:0]  b_amt,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HALF_W = DATA_W / 2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] data_n;
  logic [AMT_W-1:0]  cnt, cnt_n;
  logic [1:0]        op_q, op_n;
  logic [AMT_W-1:0]  amt_sel_c;
  logic [DATA_W-1:0] shifted_c;
  logic              busy_n, done_n;

  // Amount source select, evaluated only when a start is accepted.
  always_comb begin
    amt_sel_c = shamt;
    case (amt_sel)
      2'b00:   amt_sel_c = shamt;
      2'b01:   amt_sel_c = mdr_amt;
      2'b10:   amt_sel_c = b_amt;
      default: amt_sel_c = AMT_W'(HALF_W);
    endcase
  end

  // One-bit step of the latched operation.
  always_comb begin
    shifted_c = {1'b0, data_out[DATA_W-1:1]};
    case (op_q)
      OP_SLL:  shifted_c = {data_out[DATA_W-2:0], 1'b0};
      OP_SRL:  shifted_c = {1'b0, data_out[DATA_W-1:1]};
      OP_SRA:  shifted_c = {data_out[DATA_W-1], data_out[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
      default: shifted_c = {data_out[0], data_out[DATA_W-1:1]};
`else
      default: shifted_c = {1'b0, data_out[DATA_W-1:1]};
`endif
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    data_n  = data_out;
    cnt_n   = cnt;
    op_n    = op_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          data_n  = data_in;
          op_n    = op;
          cnt_n   = amt_sel_c;
          // A zero amount completes on the accept edge itself.
          state_n = (amt_sel_c == '0) ? DONE : SHIFT;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        data_n = shifted_c;
        cnt_n  = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  // State register; flags are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      op_q     <= OP_SLL;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      data_out <= data_n;
      cnt      <= cnt_n;
      op_q     <= op_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_shift_amt_unit.sv
// tb_shift_amt_unit: directed self-checking bench for shift_amt_unit.
// Honours SHIFT_ROTATE_EN the same way as the design for the rotate case.
module tb_shift_amt_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  amt_sel;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [4:0]  mdr_amt;
  logic [4:0]  b_amt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int check_cnt = 0;

  shift_amt_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .amt_sel  (amt_sel),
    .op       (op),
    .shamt    (shamt),
    .mdr_amt  (mdr_amt),
    .b_amt    (b_amt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; amt_sel = 2'b00; op = 2'b00;
    shamt = 5'd3; mdr_amt = 5'd0; b_amt = 5'd0; data_in = 32'hFFFF_FFFF;
    step(); step();
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_cnt++; if (data_out !== 32'h0) $display("FAIL reset_data cyc%0d got %h exp 0", i, data_out); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy); else pass_cnt++;
      check_cnt++; if (done !== 1'b0) $display("FAIL reset_done cyc%0d got %b exp 0", i, done); else pass_cnt++;
    end
  endtask

  task automatic test_sll;
    data_in = 32'h0000_0001; op = 2'b00; amt_sel = 2'b00; shamt = 5'd4; start = 1'b1;
    step();
    start = 1'b0; data_in = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      check_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL sll_busy cyc%0d got busy=%b done=%b exp 1/0", i, busy, done); else pass_cnt++;
      step();
    end
    check_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL sll_done got done=%b busy=%b exp 1/0", done, busy); else pass_cnt++;
    check_cnt++; if (data_out !== 32'h0000_0010) $display("FAIL sll_data got %h exp 00000010", data_out); else pass_cnt++;
    step();
    check_cnt++; if (done !== 1'b0) $display("FAIL sll_done_pulse got %b exp 0", done); else pass_cnt++;
    check_cnt++; if (data_out !== 32'h0000_0010) $display("FAIL sll_hold got %h exp 00000010", data_out); else pass_cnt++;
  endtask

  task automatic test_sra_ignore_start;
    int n;
    data_in = 32'h8000_0000; op = 2'b10; amt_sel = 2'b10; b_amt = 5'd31; start = 1'b1;
    step();
    start = 1'b0; op = 2'b00; b_amt = 5'd2; amt_sel = 2'b00; data_in = 32'h0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      start = (n == 10);
      step();
      n++;
    end
    start = 1'b0;
    check_cnt++; if (n !== 31) $display("FAIL sra_latency got %0d exp 31", n); else pass_cnt++;
    check_cnt++; if (data_out !== 32'hFFFF_FFFF) $display("FAIL sra_data got %h exp ffffffff", data_out); else pass_cnt++;
  endtask

  task automatic test_srl_const_then_zero;
    int n;
    data_in = 32'h1234_ABCD; op = 2'b01; amt_sel = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_cnt++; if (n !== 16) $display("FAIL srl_latency got %0d exp 16", n); else pass_cnt++;
    check_cnt++; if (data_out !== 32'h0000_1234) $display("FAIL srl_data got %h exp 00001234", data_out); else pass_cnt++;
    // Back-to-back from DONE with a zero amount.
    amt_sel = 2'b01; mdr_amt = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done got done=%b busy=%b exp 1/0", done, busy); else pass_cnt++;
    check_cnt++; if (data_out !== 32'h1234_ABCD) $display("FAIL zero_data got %h exp 1234abcd", data_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    data_in = 32'h0000_0001; op = 2'b00; amt_sel = 2'b00; shamt = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    check_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept got done=%b busy=%b exp 0/1", done, busy); else pass_cnt++;
    step();
    check_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b exp 1", busy); else pass_cnt++;
    step();
    check_cnt++; if (done !== 1'b1 || data_out !== 32'h0000_0004) $display("FAIL b2b_result got done=%b data=%h exp 1/00000004", done, data_out); else pass_cnt++;
    step();
  endtask

  task automatic test_rotate;
    logic [31:0] exp_v;
`ifdef SHIFT_ROTATE_EN
    exp_v = 32'h8000_0001;
`else
    exp_v = 32'h0000_0001;
`endif
    data_in = 32'h0000_0003; op = 2'b11; amt_sel = 2'b00; shamt = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_cnt++; if (done !== 1'b1 || data_out !== exp_v) $display("FAIL rotate got done=%b data=%h exp 1/%h", done, data_out, exp_v); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    data_in = 32'h0000_0001; op = 2'b00; amt_sel = 2'b00; shamt = 5'd10; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check_cnt++; if (data_out !== 32'h0000_0004) $display("FAIL abort_mid got %h exp 00000004", data_out); else pass_cnt++;
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check_cnt++; if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) $display("FAIL abort_reset got busy=%b done=%b data=%h exp 0/0/0", busy, done, data_out); else pass_cnt++;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== 32'h0) saw_done = 1'b1;
    end
    check_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_quiet got activity=%b exp 0", saw_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_ignore_start();
    test_srl_const_then_zero();
    test_back_to_back();
    test_rotate();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
